adc_sequencer: RTL and testbench

Conversion initiator for the SAR ADC controller. It issues periodic single-cycle start pulses, captures each result on the controller's one-cycle ready strobe, and averages 2^AVG_LOG2 consecutive results. Averaged results go out on a one-entry valid/ready output register. It sits between the SAR controller and the digital consumer (register file / stream sink), and flags lost results and stalled conversions.

---
 rtl/adc_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_adc_sequencer.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_sequencer.sv
// adc_sequencer: periodic conversion initiator for the SAR ADC controller.
// Issues single-cycle start pulses, averages 2**AVG_LOG2 results and hands
// them to the consumer through a one-entry valid/ready output register.
// Sticky flags report dropped averages and conversions that never finished.
module adc_sequencer #(
    parameter int RESOLUTION = 4,
    parameter int AVG_LOG2   = 2,
    parameter int PERIOD_W   = 16,
    parameter int TIMEOUT    = 64
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           en_i,
    input  logic [PERIOD_W-1:0]            period_i,
    input  logic                           clr_i,
    output logic                           start_o,
    input  logic                           adc_rdy_i,
    input  logic [RESOLUTION-1:0]          adc_data_i,
    output logic                           valid_o,
    input  logic                           ready_i,
    output logic [RESOLUTION-1:0]          data_o,
    output logic [RESOLUTION+AVG_LOG2-1:0] sum_o,
    output logic                           overrun_o,
    output logic                           timeout_o,
    output logic                           busy_o
);

    localparam int SUM_W = RESOLUTION + AVG_LOG2;
    localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    // The ADC needs RESOLUTION bit cycles plus handshake overhead per sample.
    localparam logic [PERIOD_W-1:0] MIN_PERIOD  = PERIOD_W'(RESOLUTION + 4);
    localparam logic [CNT_W-1:0]    LAST_SAMPLE = CNT_W'((1 << AVG_LOG2) - 1);
    localparam logic [TMO_W-1:0]    TMO_LAST    = TMO_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT,
        ARM
    } state_e;

    state_e                state_q, state_d;
    logic [PERIOD_W-1:0]   period_q, period_d;
    logic [TMO_W-1:0]      tmo_q, tmo_d;        // cycles spent waiting for adc_rdy_i
    logic [SUM_W-1:0]      acc_q, acc_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  start_q, start_d;
    logic                  valid_q, valid_d;
    logic [RESOLUTION-1:0] data_q, data_d;
    logic [SUM_W-1:0]      sum_q, sum_d;
    logic                  overrun_q, overrun_d;
    logic                  timeout_q, timeout_d;

    logic [PERIOD_W-1:0]   period_dec;
    logic [PERIOD_W-1:0]   eff_period;
    logic [SUM_W-1:0]      total;
    logic [SUM_W-1:0]      total_shr;
    logic                  avg_done;
    logic                  tmo_hit;

    assign period_dec = (period_q == '0) ? '0 : period_q - PERIOD_W'(1);
    assign eff_period = (period_i < MIN_PERIOD) ? MIN_PERIOD : period_i;
    assign total      = acc_q + SUM_W'(adc_data_i);
    assign total_shr  = total >> AVG_LOG2;

    // Sequencing FSM: start pulse, conversion wait, inter-start spacing.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path infers a latch.
        state_d  = state_q;
        period_d = period_q;
        tmo_d    = tmo_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        start_d  = 1'b0;
        avg_done = 1'b0;
        tmo_hit  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (en_i) state_d = START;
            end
            START: begin
                // start_o is registered, so it appears during the first WAIT cycle.
                start_d  = 1'b1;
                period_d = eff_period - PERIOD_W'(1);
                tmo_d    = '0;
                state_d  = WAIT;
            end
            WAIT: begin
                period_d = period_dec;
                tmo_d    = tmo_q + TMO_W'(1);
                if (adc_rdy_i) begin
                    state_d = ARM;
                    if (cnt_q == LAST_SAMPLE) begin
                        avg_done = 1'b1;
                        acc_d    = '0;
                        cnt_d    = '0;
                    end else begin
                        acc_d = total;
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else if (tmo_q == TMO_LAST) begin
                    tmo_hit = 1'b1;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = ARM;
                end
            end
            ARM: begin
                period_d = period_dec;
                if (!en_i) begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (period_dec == '0) begin
                    // Leaving when the counter is about to hit zero keeps starts
                    // exactly eff_period cycles apart.
                    state_d = START;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output register and sticky flags; a set in the same cycle as clr_i wins.
    always_comb begin
        valid_d   = valid_q;
        data_d    = data_q;
        sum_d     = sum_q;
        overrun_d = overrun_q & ~clr_i;
        timeout_d = (timeout_q & ~clr_i) | tmo_hit;
        if (avg_done) begin
            if (!valid_q || ready_i) begin
                valid_d = 1'b1;
                data_d  = total_shr[RESOLUTION-1:0];
                sum_d   = total;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            period_q  <= '0;
            tmo_q     <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            start_q   <= 1'b0;
            valid_q   <= 1'b0;
            data_q    <= '0;
            sum_q     <= '0;
            overrun_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q   <= state_d;
            period_q  <= period_d;
            tmo_q     <= tmo_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            start_q   <= start_d;
            valid_q   <= valid_d;
            data_q    <= data_d;
            sum_q     <= sum_d;
            overrun_q <= overrun_d;
            timeout_q <= timeout_d;
        end
    end

    assign start_o   = start_q;
    assign valid_o   = valid_q;
    assign data_o    = data_q;
    assign sum_o     = sum_q;
    assign overrun_o = overrun_q;
    assign timeout_o = timeout_q;
    assign busy_o    = (state_q != IDLE);

endmodule

// File: tb/tb_adc_sequencer.sv
// tb_adc_sequencer: directed scenarios with randomized ADC data and response
// delays, checked against a conversion-level model of the sequencer.
module tb_adc_sequencer;

    localparam int RES   = 4;
    localparam int AVG   = 2;
    localparam int PW    = 16;
    localparam int TMO   = 64;
    localparam int NS    = 1 << AVG;
    localparam int MINP  = RES + 4;
    localparam int BOUND = 300;

    logic              clk        = 1'b0;
    logic              rst_ni     = 1'b0;
    logic              en_i       = 1'b0;
    logic [PW-1:0]     period_i   = PW'(20);
    logic              clr_i      = 1'b0;
    logic              start_o;
    logic              adc_rdy_i  = 1'b0;
    logic [RES-1:0]    adc_data_i = '0;
    logic              valid_o;
    logic              ready_i    = 1'b1;
    logic [RES-1:0]    data_o;
    logic [RES+AVG-1:0] sum_o;
    logic              overrun_o;
    logic              timeout_o;
    logic              busy_o;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;
    int exp_start;
    int n_st;
    bit seen;

    // Reference model state: pending samples and expected output register/flags.
    int q[$];
    bit m_valid = 1'b0;
    int m_sum   = 0;
    bit m_ovr   = 1'b0;
    bit m_tmo   = 1'b0;

    adc_sequencer #(
        .RESOLUTION(RES),
        .AVG_LOG2  (AVG),
        .PERIOD_W  (PW),
        .TIMEOUT   (TMO)
    ) dut (
        .clk_i     (clk),
        .rst_ni    (rst_ni),
        .en_i      (en_i),
        .period_i  (period_i),
        .clr_i     (clr_i),
        .start_o   (start_o),
        .adc_rdy_i (adc_rdy_i),
        .adc_data_i(adc_data_i),
        .valid_o   (valid_o),
        .ready_i   (ready_i),
        .data_o    (data_o),
        .sum_o     (sum_o),
        .overrun_o (overrun_o),
        .timeout_o (timeout_o),
        .busy_o    (busy_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int eff(input int p);
        return (p < MINP) ? MINP : p;
    endfunction

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // One conversion: wait for start_o, answer after dly cycles (or never, to
    // force a timeout), then compare outputs against the model.
    task automatic conv(input int dly, input bit rdy_on, input int val,
                        input bit drop_en = 1'b0, input bit clr_at_rdy = 1'b0);
        int t_start;
        int t_rdy;
        int total;
        bit got;
        bit done;
        got  = 1'b0;
        done = 1'b0;
        for (int i = 0; i < BOUND && !got; i++) begin
            step();
            if (start_o) got = 1'b1;
        end
        check("start_seen", got, 1);
        if (!got) return;
        t_start = cyc;
        check("start_time", t_start, exp_start);
        check("busy_at_start", busy_o, 1);
        for (int i = 0; i < dly; i++) begin
            step();
            if (i == 0) begin
                check("start_width", start_o, 0);
                if (drop_en) en_i = 1'b0;
            end
        end
        t_rdy = cyc;
        if (rdy_on) begin
            adc_rdy_i  = 1'b1;
            adc_data_i = RES'(val);
        end else begin
            check("timeout_not_early", timeout_o, m_tmo);
        end
        if (clr_at_rdy) clr_i = 1'b1;
        step();
        adc_rdy_i  = 1'b0;
        clr_i      = 1'b0;
        adc_data_i = RES'($urandom);

        if (clr_at_rdy) begin
            m_ovr = 1'b0;
            m_tmo = 1'b0;
        end
        if (!rdy_on) begin
            q.delete();
            m_tmo = 1'b1;
        end else begin
            q.push_back(val);
            if (q.size() == NS) begin
                total = 0;
                foreach (q[k]) total += q[k];
                q.delete();
                done = 1'b1;
                if (!m_valid || ready_i) begin
                    m_valid = 1'b1;
                    m_sum   = total;
                end else begin
                    m_ovr = 1'b1;
                end
            end
        end
        if (!done && ready_i) m_valid = 1'b0;
        if (drop_en) q.delete();

        check("valid", valid_o, m_valid);
        if (m_valid) begin
            check("sum", sum_o, m_sum);
            check("data", data_o, m_sum / NS);
        end
        check("overrun", overrun_o, m_ovr);
        check("timeout", timeout_o, m_tmo);

        exp_start = imax(t_start + eff(int'(period_i)), t_rdy + 3);

        if (done && ready_i) begin
            step();
            check("valid_one_cycle", valid_o, 0);
            m_valid = 1'b0;
        end
    endtask

    initial begin
        // Reset state
        repeat (3) step();
        check("rst_start", start_o, 0);
        check("rst_valid", valid_o, 0);
        check("rst_data", data_o, 0);
        check("rst_sum", sum_o, 0);
        check("rst_overrun", overrun_o, 0);
        check("rst_timeout", timeout_o, 0);
        check("rst_busy", busy_o, 0);
        rst_ni = 1'b1;
        repeat (2) step();
        check("idle_busy", busy_o, 0);

        // Fixed samples 3,4,5,6 at period 20: sum 18, average 4
        en_i      = 1'b1;
        exp_start = cyc + 2;
        conv(6, 1'b1, 3);
        conv(6, 1'b1, 4);
        conv(6, 1'b1, 5);
        conv(6, 1'b1, 6);
        check("s1_sum", sum_o, 18);
        check("s1_data", data_o, 4);

        // Period below the minimum clamps to 8; delays straddle the period end
        period_i = PW'(2);
        for (int i = 0; i < 2 * NS; i++)
            conv($urandom_range(1, 9), 1'b1, $urandom_range(0, 15));

        // Consumer stalls across two averages; second one is dropped while clr_i
        // pulses in the same cycle, so the overrun set must win
        ready_i = 1'b0;
        for (int i = 0; i < 2 * NS; i++)
            conv($urandom_range(1, 5), 1'b1, $urandom_range(0, 15), 1'b0, i == 2 * NS - 1);
        ready_i = 1'b1;
        clr_i   = 1'b1;
        step();
        clr_i = 1'b0;
        check("handshake_clears_valid", valid_o, 0);
        check("clr_overrun", overrun_o, 0);
        m_valid = 1'b0;
        m_ovr   = 1'b0;
        m_tmo   = 1'b0;

        // Timeout after two samples discards them; next average uses 4 fresh ones
        conv($urandom_range(1, 5), 1'b1, $urandom_range(0, 15));
        conv($urandom_range(1, 5), 1'b1, $urandom_range(0, 15));
        conv(TMO - 1, 1'b0, 0);
        for (int i = 0; i < NS; i++)
            conv($urandom_range(1, 5), 1'b1, $urandom_range(0, 15));

        // Disable during WAIT: the pending conversion completes, then idle
        conv($urandom_range(1, 5), 1'b1, $urandom_range(0, 15));
        conv($urandom_range(1, 5), 1'b1, $urandom_range(0, 15));
        conv(3, 1'b1, $urandom_range(0, 15), 1'b1);
        step();
        check("disable_busy", busy_o, 0);
        n_st = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (start_o) n_st++;
        end
        check("disable_no_start", n_st, 0);
        en_i      = 1'b1;
        exp_start = cyc + 2;
        for (int i = 0; i < NS; i++)
            conv($urandom_range(1, 5), 1'b1, $urandom_range(0, 15));

        // Reset during WAIT with two samples accumulated
        conv($urandom_range(1, 5), 1'b1, $urandom_range(0, 15));
        conv($urandom_range(1, 5), 1'b1, $urandom_range(0, 15));
        seen = 1'b0;
        for (int i = 0; i < BOUND && !seen; i++) begin
            step();
            if (start_o) seen = 1'b1;
        end
        check("pre_reset_start_seen", seen, 1);
        repeat (2) step();
        rst_ni = 1'b0;
        step();
        check("mid_rst_start", start_o, 0);
        check("mid_rst_valid", valid_o, 0);
        check("mid_rst_data", data_o, 0);
        check("mid_rst_sum", sum_o, 0);
        check("mid_rst_overrun", overrun_o, 0);
        check("mid_rst_timeout", timeout_o, 0);
        check("mid_rst_busy", busy_o, 0);
        q.delete();
        m_valid = 1'b0;
        m_sum   = 0;
        m_ovr   = 1'b0;
        m_tmo   = 1'b0;
        rst_ni    = 1'b1;
        exp_start = cyc + 2;
        for (int i = 0; i < NS; i++)
            conv($urandom_range(1, 5), 1'b1, $urandom_range(0, 15));
        check("post_rst_sum", sum_o, m_sum);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
